// File: rtl/stage_handshake_responder_if.sv
// Stage-enable / stage-done bundle between the control unit (master) and the
// stage handshake responder (slave).
interface stage_handshake_responder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             fetch_req;
  logic             decode_req;
  logic             execute_req;
  logic             wb_req;
  logic             fetch_done;
  logic             decode_done;
  logic             execute_done;
  logic             wb_done;
  logic             busy;
  logic [2:0]       stage;
  logic             seq_err;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output fetch_req, decode_req, execute_req, wb_req,
    input  fetch_done, decode_done, execute_done, wb_done,
    input  busy, stage, seq_err, retired_count
  );

  modport slave (
    input  fetch_req, decode_req, execute_req, wb_req,
    output fetch_done, decode_done, execute_done, wb_done,
    output busy, stage, seq_err, retired_count
  );
endinterface

// File: rtl/stage_handshake_responder.sv
// Responder for the fetch/decode/execute/write-back sequencer protocol: models
// per-stage latency, pulses done, checks ordering and counts retirements.
module stage_handshake_responder #(
  parameter int unsigned FETCH_LAT  = 1,
  parameter int unsigned DECODE_LAT = 1,
  parameter int unsigned EXEC_LAT   = 2,
  parameter int unsigned WB_LAT     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  stage_handshake_responder_if.slave   io_hs
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned N_STG = 4;

  // Latencies must fit the 4-bit down-counter and be at least one cycle.
  if (FETCH_LAT < 1 || FETCH_LAT > 15) begin : g_bad_fetch_lat
    $error("FETCH_LAT must be in 1..15");
  end
  if (DECODE_LAT < 1 || DECODE_LAT > 15) begin : g_bad_decode_lat
    $error("DECODE_LAT must be in 1..15");
  end
  if (EXEC_LAT < 1 || EXEC_LAT > 15) begin : g_bad_exec_lat
    $error("EXEC_LAT must be in 1..15");
  end
  if (WB_LAT < 1 || WB_LAT > 15) begin : g_bad_wb_lat
    $error("WB_LAT must be in 1..15");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_BUSY,
    S_D_BUSY,
    S_E_BUSY,
    S_W_BUSY,
    S_AWAIT_D,
    S_AWAIT_E,
    S_AWAIT_W,
    S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_target;
  state_t           w_after;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_nxt;
  logic [LAT_W-1:0] w_load;
  logic [N_STG-1:0] r_prev;
  logic [N_STG-1:0] w_req;
  logic [N_STG-1:0] w_rise;
  logic [N_STG-1:0] w_expect;
  logic [N_STG-1:0] w_done_sel;
  logic [N_STG-1:0] r_done;
  logic [N_STG-1:0] w_done_nxt;
  logic             w_retire;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [2:0]       r_stage;
  logic [2:0]       w_stage_nxt;
  logic             r_seq_err;
  logic             w_seq_err_nxt;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] w_retired_nxt;

  // Bit order everywhere: [0]=fetch, [1]=decode, [2]=execute, [3]=write-back.
  assign w_req  = {io_hs.wb_req, io_hs.execute_req, io_hs.decode_req, io_hs.fetch_req};
  assign w_rise = w_req & ~r_prev;

  // Per-state protocol table: what request is expected, where it leads, and
  // what a finishing busy state emits.
  always_comb begin
    w_expect   = '0;
    w_target   = S_ERROR;
    w_load     = '0;
    w_done_sel = '0;
    w_after    = S_ERROR;
    w_retire   = 1'b0;
    case (r_state)
      S_IDLE:    begin w_expect = 4'b0001; w_target = S_F_BUSY; w_load = LAT_W'(FETCH_LAT - 1);  end
      S_AWAIT_D: begin w_expect = 4'b0010; w_target = S_D_BUSY; w_load = LAT_W'(DECODE_LAT - 1); end
      S_AWAIT_E: begin w_expect = 4'b0100; w_target = S_E_BUSY; w_load = LAT_W'(EXEC_LAT - 1);   end
      S_AWAIT_W: begin w_expect = 4'b1000; w_target = S_W_BUSY; w_load = LAT_W'(WB_LAT - 1);     end
      S_F_BUSY:  begin w_done_sel = 4'b0001; w_after = S_AWAIT_D; end
      S_D_BUSY:  begin w_done_sel = 4'b0010; w_after = S_AWAIT_E; end
      S_E_BUSY:  begin w_done_sel = 4'b0100; w_after = S_AWAIT_W; end
      S_W_BUSY:  begin w_done_sel = 4'b1000; w_after = S_IDLE; w_retire = 1'b1; end
      default:   ;
    endcase
  end

  // Next state, latency counter and next registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = '0;
    w_retired_nxt = r_retired;
    case (r_state)
      S_IDLE, S_AWAIT_D, S_AWAIT_E, S_AWAIT_W: begin
        // Anything other than exactly the expected single edge is a violation.
        if (w_rise != '0) begin
          if (w_rise == w_expect) begin
            w_state_nxt = w_target;
            w_cnt_nxt   = w_load;
          end else begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      S_F_BUSY, S_D_BUSY, S_E_BUSY, S_W_BUSY: begin
        if (w_rise != '0) begin
          w_state_nxt = S_ERROR;
        end else if (r_cnt == '0) begin
          w_state_nxt = w_after;
          w_done_nxt  = w_done_sel;
          if (w_retire) begin
            w_retired_nxt = r_retired + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - LAT_W'(1);
        end
      end
      default: w_state_nxt = S_ERROR;
    endcase

    w_busy_nxt    = 1'b0;
    w_seq_err_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE:    w_stage_nxt = 3'd0;
      S_F_BUSY:  begin w_stage_nxt = 3'd1; w_busy_nxt = 1'b1; end
      S_D_BUSY:  begin w_stage_nxt = 3'd2; w_busy_nxt = 1'b1; end
      S_E_BUSY:  begin w_stage_nxt = 3'd3; w_busy_nxt = 1'b1; end
      S_W_BUSY:  begin w_stage_nxt = 3'd4; w_busy_nxt = 1'b1; end
      S_AWAIT_D: w_stage_nxt = 3'd1;
      S_AWAIT_E: w_stage_nxt = 3'd2;
      S_AWAIT_W: w_stage_nxt = 3'd3;
      default:   begin w_stage_nxt = 3'd5; w_seq_err_nxt = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_prev    <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_stage   <= 3'd0;
      r_seq_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_prev    <= w_req;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_stage   <= w_stage_nxt;
      r_seq_err <= w_seq_err_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign io_hs.fetch_done    = r_done[0];
  assign io_hs.decode_done   = r_done[1];
  assign io_hs.execute_done  = r_done[2];
  assign io_hs.wb_done       = r_done[3];
  assign io_hs.busy          = r_busy;
  assign io_hs.stage         = r_stage;
  assign io_hs.seq_err       = r_seq_err;
  assign io_hs.retired_count = r_retired;

endmodule

// File: tb/tb_stage_handshake_responder.sv
// Scoreboard bench for stage_handshake_responder: directed stimulus pushes
// expected done pulses, a negedge monitor pops and compares them.
module tb_stage_handshake_responder;

  logic clk;
  logic reset;
  logic f_req, d_req, e_req, w_req;

  stage_handshake_responder_if #(.CNT_W(16)) hs16 ();
  stage_handshake_responder_if #(.CNT_W(4))  hs4 ();

  assign hs16.fetch_req   = f_req;
  assign hs16.decode_req  = d_req;
  assign hs16.execute_req = e_req;
  assign hs16.wb_req      = w_req;
  assign hs4.fetch_req    = f_req;
  assign hs4.decode_req   = d_req;
  assign hs4.execute_req  = e_req;
  assign hs4.wb_req       = w_req;

  stage_handshake_responder #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .io_hs (hs16.slave)
  );

  stage_handshake_responder #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .io_hs (hs4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int base     = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         edge_i;
    logic [3:0] done;
    int         ret;
  } ev_t;

  ev_t sb[$];

  function automatic int rel();
    return edge_n - 1 - base;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, rel(), act, exp);
    end
  endtask

  function automatic logic [63:0] outs16();
    return 64'({hs16.wb_done, hs16.execute_done, hs16.decode_done, hs16.fetch_done,
                hs16.busy, hs16.stage, hs16.seq_err, hs16.retired_count});
  endfunction

  task automatic push(input int e, input logic [3:0] d, input int r);
    ev_t ev;
    ev.edge_i = e;
    ev.done   = d;
    ev.ret    = r;
    sb.push_back(ev);
  endtask

  task automatic wait_after(input int k);
    while (rel() < k) @(negedge clk);
  endtask

  // Inputs set here are sampled at scenario edge k.
  task automatic at(input int k);
    wait_after(k - 1);
  endtask

  task automatic set_in(input logic r, input logic [3:0] q);
    reset = r;
    f_req = q[0];
    d_req = q[1];
    e_req = q[2];
    w_req = q[3];
  endtask

  task automatic begin_scen();
    @(negedge clk);
    base = edge_n;
  endtask

  task automatic reset_prefix();
    begin_scen();
    for (int k = 0; k < 3; k++) begin
      at(k);
      set_in(1'b1, 4'b0000);
    end
    at(3);
    set_in(1'b0, 4'b0000);
  endtask

  task automatic drain();
    chk("sb_drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0] dn;
    ev_t        ev;
    dn = {hs16.wb_done, hs16.execute_done, hs16.decode_done, hs16.fetch_done};
    if (dn != 4'b0000) begin
      chk("done_onehot", 64'($countones(dn)), 64'd1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done edge=%0d actual=%b required=none", rel(), dn);
      end else begin
        ev = sb.pop_front();
        chk("done_edge",    64'(rel()), 64'(ev.edge_i));
        chk("done_which",   64'(dn), 64'(ev.done));
        chk("done_retired", 64'(hs16.retired_count), 64'(ev.ret));
      end
    end
  end

  function automatic logic [3:0] full_q(input int k);
    case (k)
      10: return 4'b0001;
      13: return 4'b0010;
      16: return 4'b0100;
      20: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int full_stage(input int k);
    if (k < 10) return 0;
    if (k < 13) return 1;
    if (k < 16) return 2;
    if (k < 20) return 3;
    if (k < 21) return 4;
    return 0;
  endfunction

  initial begin
    set_in(1'b1, 4'b0000);

    // Reset held 0..4 while requests toggle; all outputs stay 0 through 5.
    begin_scen();
    for (int k = 0; k < 5; k++) begin
      at(k);
      set_in(1'b1, 4'(k * 5 + 1));
      wait_after(k);
      chk("reset_outs", outs16(), 64'd0);
    end
    at(5);
    set_in(1'b0, 4'b0000);
    wait_after(5);
    chk("reset_release_outs", outs16(), 64'd0);

    // Full clean sequence with one-cycle request pulses.
    reset_prefix();
    push(11, 4'b0001, 0);
    push(14, 4'b0010, 0);
    push(18, 4'b0100, 0);
    push(21, 4'b1000, 1);
    for (int k = 4; k < 24; k++) begin
      at(k);
      set_in(1'b0, full_q(k));
      wait_after(k);
      if (k >= 9) begin
        chk("full_busy",  64'(hs16.busy), 64'(k == 10 || k == 13 || k == 16 || k == 17 || k == 20));
        chk("full_stage", 64'(hs16.stage), 64'(full_stage(k)));
        chk("full_seq_err", 64'(hs16.seq_err), 64'd0);
      end
    end
    chk("full_retired", 64'(hs16.retired_count), 64'd1);
    drain();

    // Out of order: decode first from IDLE, error is sticky until reset.
    reset_prefix();
    for (int k = 4; k < 34; k++) begin
      at(k);
      set_in(k == 30, {k >= 16 && k < 20, k >= 14 && k < 20, k >= 10 && k < 20,
                       (k >= 12 && k < 20) || k == 22});
      wait_after(k);
      if (k >= 10 && k < 30) begin
        chk("ooo_stage",   64'(hs16.stage), 64'd5);
        chk("ooo_seq_err", 64'(hs16.seq_err), 64'd1);
        chk("ooo_busy",    64'(hs16.busy), 64'd0);
      end
      if (k == 30) chk("ooo_reset_outs", outs16(), 64'd0);
    end
    drain();

    // Write-back request while execute is still counting.
    reset_prefix();
    push(11, 4'b0001, 0);
    push(14, 4'b0010, 0);
    for (int k = 4; k < 27; k++) begin
      at(k);
      set_in(1'b0, {k == 17, k == 16, k == 13, k == 10});
      wait_after(k);
      if (k >= 17) begin
        chk("busyerr_stage",   64'(hs16.stage), 64'd5);
        chk("busyerr_seq_err", 64'(hs16.seq_err), 64'd1);
        chk("busyerr_busy",    64'(hs16.busy), 64'd0);
      end
    end
    chk("busyerr_retired", 64'(hs16.retired_count), 64'd0);
    drain();

    // Level-held enables: each stage done exactly once.
    reset_prefix();
    push(11, 4'b0001, 0);
    push(14, 4'b0010, 0);
    push(18, 4'b0100, 0);
    push(21, 4'b1000, 1);
    for (int k = 4; k < 34; k++) begin
      at(k);
      set_in(1'b0, {k >= 20 && k < 30, k >= 16 && k < 30, k >= 13 && k < 30, k >= 10 && k < 30});
      wait_after(k);
      if (k == 25 || k == 33) begin
        chk("level_stage",   64'(hs16.stage), 64'd0);
        chk("level_seq_err", 64'(hs16.seq_err), 64'd0);
        chk("level_retired", 64'(hs16.retired_count), 64'd1);
      end
    end
    drain();

    // Sixteen clean sequences: 4-bit counter wraps to 0.
    reset_prefix();
    for (int i = 0; i < 16; i++) begin
      push(10 + 12 * i + 1,  4'b0001, i);
      push(10 + 12 * i + 4,  4'b0010, i);
      push(10 + 12 * i + 8,  4'b0100, i);
      push(10 + 12 * i + 11, 4'b1000, i + 1);
    end
    for (int k = 4; k < 204; k++) begin
      int off;
      off = (k >= 10 && k < 202) ? (k - 10) % 12 : -1;
      at(k);
      set_in(1'b0, {off == 10, off == 6, off == 3, off == 0});
      wait_after(k);
      if (k == 195) chk("wrap_cnt4_allones", 64'(hs4.retired_count), 64'hF);
    end
    chk("wrap_cnt4_zero",  64'(hs4.retired_count), 64'd0);
    chk("wrap_cnt4_err",   64'(hs4.seq_err), 64'd0);
    chk("wrap_cnt16",      64'(hs16.retired_count), 64'd16);
    chk("wrap_cnt16_err",  64'(hs16.seq_err), 64'd0);
    drain();

    // Reset during execute: done suppressed, next fetch accepted normally.
    reset_prefix();
    push(11, 4'b0001, 0);
    push(14, 4'b0010, 0);
    push(21, 4'b0001, 0);
    for (int k = 4; k < 26; k++) begin
      at(k);
      set_in(k == 17, {1'b0, k == 16, k == 13, k == 10 || k == 20});
      wait_after(k);
      if (k == 17) chk("midrst_outs", outs16(), 64'd0);
      if (k == 20) begin
        chk("midrst_busy",  64'(hs16.busy), 64'd1);
        chk("midrst_stage", 64'(hs16.stage), 64'd1);
      end
      if (k == 22) begin
        chk("midrst_await_busy", 64'(hs16.busy), 64'd0);
        chk("midrst_await_stage", 64'(hs16.stage), 64'd1);
        chk("midrst_seq_err", 64'(hs16.seq_err), 64'd0);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
